squasher_sched: RTL and testbench
=================================

# squasher_sched

Round-robin scheduler that shares one `worm_squasher` engine between up to NUM_CLIENTS CPU requesters. It accepts level requests, picks one winner fairly, issues a single start pulse and selects that client's payload/header through an external mux. It then waits for the engine result and returns it to the owning client as a tagged response pulse. An optional watchdog aborts hung lookups.

## Interface
Parameters:
- NUM_CLIENTS, 4: number of requesters, 2..4.
- ID_W, 2: client id width, matches engine `clientid_o`.
- TIMEOUT, 64: watchdog limit in cycles, 2..255. Used only with SQ_SCHED_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- req_i  in  NUM_CLIENTS  per-client level request. The client holds it until its gnt_o bit pulses.
- gnt_o  out  NUM_CLIENTS  one-hot grant pulse, 1 cycle.
- sel_o  out  ID_W  client id driving the external payload/header mux. Valid from ISSUE through RESP.
- eng_start_o  out  1  engine start pulse, 1 cycle.
- eng_busy_i  in  1  engine busy; no start is issued while high.
- eng_valid_i  in  1  engine result strobe.
- eng_match_i  in  1  engine match flag, qualified by eng_valid_i.
- eng_id_i  in  ID_W  engine-reported client id, qualified by eng_valid_i.
- rsp_valid_o  out  1  response pulse, 1 cycle.
- rsp_id_o  out  ID_W  client owning the response.
- rsp_match_o  out  1  worm signature matched.
- rsp_err_o  out  1  id mismatch or timeout; rsp_match_o is forced 0.
- idle_o  out  1  scheduler in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when |req_i and !eng_busy_i.
  - The winner is the first requesting client at or after rr_ptr, searching upward with wrap-around from NUM_CLIENTS-1 to 0.
  - The winner is registered into sel_o.
- ISSUE:
  - eng_start_o=1 and gnt_o[sel_o]=1 for exactly one cycle.
  - rr_ptr ← sel_o+1, wrapping to 0 after NUM_CLIENTS-1.
  - Always goes to WAIT.
- WAIT → RESP on eng_valid_i.
  - rsp_match_o ← eng_match_i & (eng_id_i==sel_o).
  - rsp_err_o ← (eng_id_i!=sel_o).
- RESP:
  - rsp_valid_o=1 and rsp_id_o=sel_o for one cycle.
  - Then IDLE.
- eng_valid_i is ignored outside WAIT and has no side effects.
- A req_i bit that drops before its grant is simply not served. The scheduler does not commit to a winner before ISSUE.
- Bits of req_i at index ≥ NUM_CLIENTS are absent, so no out-of-range grant is possible.
- Simultaneous requests: exactly one grant per transaction. Any set of persistent requesters is each served within NUM_CLIENTS transactions.
- eng_busy_i high in IDLE stalls; requests stay pending.

## Timing
- Reset values:
  - gnt_o=0, sel_o=0, eng_start_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_match_o=0, rsp_err_o=0.
  - idle_o=1, state=IDLE, rr_ptr=0, watchdog=0.
- Request sampled at edge T → eng_start_o and gnt_o high in cycle T+1.
- eng_valid_i sampled at edge E → rsp_valid_o high in cycle E+1.
- Minimum request-to-response latency: 3 cycles plus engine latency.
- Back-to-back: the next ISSUE is at the earliest 2 cycles after RESP (RESP→IDLE→ISSUE).
- Reset asserted mid-transaction clears immediately: no response and no grant pulse. Any later engine strobe is ignored because the FSM is in IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SQ_SCHED_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in WAIT and clears on leaving WAIT.
  - When it reaches TIMEOUT-1 without eng_valid_i, go to RESP with rsp_err_o=1 and rsp_match_o=0.
  - If eng_valid_i arrives on that same cycle, eng_valid_i wins.
- SQ_SCHED_TIMEOUT_EN undefined: no counter; WAIT persists until eng_valid_i. The TIMEOUT parameter is unused.

## Structure
- Package `sq_pkg`:
  - state enum sq_sched_state_t {IDLE, ISSUE, WAIT, RESP}.
  - SQ_MAX_CLIENTS=4.
  - SQ_ID_W=2.
- One sub-module, `sq_rr_pick`: combinational rotating priority encoder (req, ptr → winner id, any). It is instantiated once in the FSM module.
- The payload/header mux stays outside this block and is driven by sel_o.

## Test plan
- Single request: req_i=4'b0001, engine returns valid with match=1 and id=0 after 4 cycles → gnt_o=0001 one cycle after the request; rsp_valid_o=1, rsp_id_o=0, rsp_match_o=1, rsp_err_o=0 one cycle after eng_valid_i.
- Fairness: req_i=4'b1111 held, each grant dropping only its bit, engine answers in 2 cycles → grant order 0,1,2,3. Then re-assert 4'b1011 with rr_ptr=0 → order 0,1,3.
- Busy stall: eng_busy_i=1 for 10 cycles with req_i=4'b0100 → no eng_start_o. Start pulse one cycle after busy falls; gnt_o=0100.
- Id mismatch: grant to client 1, engine returns id=2 with match=1 → rsp_id_o=1, rsp_err_o=1, rsp_match_o=0.
- Timeout (SQ_SCHED_TIMEOUT_EN, TIMEOUT=8): no eng_valid_i after start → rsp_valid_o with rsp_err_o=1 exactly 8 cycles after entering WAIT. A late eng_valid_i is ignored.
- Reset mid-WAIT: drop rst_ni for 1 cycle, then send eng_valid_i → all outputs at reset values, idle_o=1, no rsp_valid_o.

Source files
------------

// File: rtl/sq_pkg.sv
// Shared state encoding, limits and a one-hot helper for the squasher_sched scheduler.
package sq_pkg;

  localparam int SQ_MAX_CLIENTS = 4;
  localparam int SQ_ID_W        = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sq_sched_state_t;

  function automatic logic [SQ_MAX_CLIENTS-1:0] sq_onehot(input logic [SQ_ID_W-1:0] id);
    logic [SQ_MAX_CLIENTS-1:0] vec;
    vec     = {SQ_MAX_CLIENTS{1'b0}};
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/squasher_sched_if.sv
// Request/grant, engine and response signals of squasher_sched; master is the scheduler side.
interface squasher_sched_if
  import sq_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ID_W        = 2
);

  logic [NUM_CLIENTS-1:0] req_i;
  logic [NUM_CLIENTS-1:0] gnt_o;
  logic [ID_W-1:0]        sel_o;
  logic                   eng_start_o;
  logic                   eng_busy_i;
  logic                   eng_valid_i;
  logic                   eng_match_i;
  logic [ID_W-1:0]        eng_id_i;
  logic                   rsp_valid_o;
  logic [ID_W-1:0]        rsp_id_o;
  logic                   rsp_match_o;
  logic                   rsp_err_o;
  logic                   idle_o;

  modport master (
    input  req_i, eng_busy_i, eng_valid_i, eng_match_i, eng_id_i,
    output gnt_o, sel_o, eng_start_o, rsp_valid_o, rsp_id_o, rsp_match_o, rsp_err_o, idle_o
  );

  modport slave (
    output req_i, eng_busy_i, eng_valid_i, eng_match_i, eng_id_i,
    input  gnt_o, sel_o, eng_start_o, rsp_valid_o, rsp_id_o, rsp_match_o, rsp_err_o, idle_o
  );

endinterface

// File: rtl/sq_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping past NUM_CLIENTS-1.
module sq_rr_pick
  import sq_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ID_W        = 2
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  output logic [ID_W-1:0]        winner,
  output logic                   any
);

  logic [2*NUM_CLIENTS-1:0] dbl_s;
  logic [NUM_CLIENTS-1:0]   rot_s;
  logic [ID_W:0]            sum_s;
  logic [ID_W:0]            cand_s;

  // Rotate so that bit 0 is the client at ptr, then take the lowest set bit.
  always_comb begin
    dbl_s  = {req, req} >> ptr;
    rot_s  = dbl_s[NUM_CLIENTS-1:0];
    any    = |rot_s;
    winner = {ID_W{1'b0}};
    sum_s  = {(ID_W+1){1'b0}};
    cand_s = {(ID_W+1){1'b0}};
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      sum_s  = {1'b0, ptr} + (ID_W+1)'(i);
      cand_s = (sum_s >= (ID_W+1)'(NUM_CLIENTS)) ? (sum_s - (ID_W+1)'(NUM_CLIENTS)) : sum_s;
      winner = rot_s[i] ? cand_s[ID_W-1:0] : winner;
    end
  end

endmodule

// File: rtl/squasher_sched.sv
// Round-robin arbiter sharing one worm_squasher engine; SQ_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module squasher_sched
  import sq_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT     = 64
) (
  input logic              clk_i,
  input logic              rst_ni,
  squasher_sched_if.master bus
);

  sq_sched_state_t        state_r;
  sq_sched_state_t        state_s;
  logic [ID_W-1:0]        sel_r;
  logic [ID_W-1:0]        rr_ptr_r;
  logic [NUM_CLIENTS-1:0] gnt_r;
  logic                   start_r;
  logic                   rsp_valid_r;
  logic [ID_W-1:0]        rsp_id_r;
  logic                   rsp_match_r;
  logic                   rsp_err_r;
  logic                   idle_r;

  logic [ID_W-1:0]           pick_id_s;
  logic                      pick_any_s;
  logic [SQ_MAX_CLIENTS-1:0] onehot_s;
  logic [NUM_CLIENTS-1:0]    gnt_next_s;
  logic                      id_ok_s;
  logic                      timeout_s;

  sq_rr_pick #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .ID_W       (ID_W)
  ) u_pick (
    .req   (bus.req_i),
    .ptr   (rr_ptr_r),
    .winner(pick_id_s),
    .any   (pick_any_s)
  );

  // Grant vector for the current pick and engine id check against the owner.
  always_comb begin
    onehot_s   = sq_onehot(SQ_ID_W'(pick_id_s));
    gnt_next_s = onehot_s[NUM_CLIENTS-1:0];
    id_ok_s    = (bus.eng_id_i == sel_r);
  end

`ifdef SQ_SCHED_TIMEOUT_EN
  logic [7:0] wd_r;

  // Watchdog runs only while WAIT persists and restarts from zero on every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_r <= 8'd0;
    end else begin
      wd_r <= ((state_r == WAIT) && (state_s == WAIT)) ? (wd_r + 8'd1) : 8'd0;
    end
  end

  assign timeout_s = (state_r == WAIT) && (wd_r == 8'(TIMEOUT - 1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^8'(TIMEOUT);
  assign timeout_s        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the winner is only committed on the IDLE to ISSUE edge.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = (pick_any_s && !bus.eng_busy_i) ? ISSUE : IDLE;
      ISSUE:   state_s = WAIT;
      WAIT:    state_s = (bus.eng_valid_i || timeout_s) ? RESP : WAIT;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered outputs; pulses default low and are raised on the edge entering ISSUE/RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_r       <= {ID_W{1'b0}};
      rr_ptr_r    <= {ID_W{1'b0}};
      gnt_r       <= {NUM_CLIENTS{1'b0}};
      start_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_match_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      idle_r      <= 1'b1;
    end else begin
      gnt_r       <= {NUM_CLIENTS{1'b0}};
      start_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      idle_r      <= (state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (state_s == ISSUE) begin
            sel_r   <= pick_id_s;
            gnt_r   <= gnt_next_s;
            start_r <= 1'b1;
          end
        end
        ISSUE: begin
          rr_ptr_r <= (sel_r == ID_W'(NUM_CLIENTS - 1)) ? {ID_W{1'b0}} : (sel_r + ID_W'(1));
        end
        WAIT: begin
          if (bus.eng_valid_i) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= sel_r;
            rsp_match_r <= bus.eng_match_i & id_ok_s;
            rsp_err_r   <= ~id_ok_s;
          end else if (timeout_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= sel_r;
            rsp_match_r <= 1'b0;
            rsp_err_r   <= 1'b1;
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o       = gnt_r;
  assign bus.sel_o       = sel_r;
  assign bus.eng_start_o = start_r;
  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_id_o    = rsp_id_r;
  assign bus.rsp_match_o = rsp_match_r;
  assign bus.rsp_err_o   = rsp_err_r;
  assign bus.idle_o      = idle_r;

endmodule

// File: tb/tb_squasher_sched.sv
// Directed self-checking bench for squasher_sched; the timeout case runs when SQ_SCHED_TIMEOUT_EN is defined.
module tb_squasher_sched;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  squasher_sched_if #(.NUM_CLIENTS(4), .ID_W(2)) bus ();

  squasher_sched #(
    .NUM_CLIENTS(4),
    .ID_W       (2),
    .TIMEOUT    (8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt_o),       32'd0);
    check({tag, "_sel"},   32'(bus.sel_o),       32'd0);
    check({tag, "_start"}, 32'(bus.eng_start_o), 32'd0);
    check({tag, "_rspv"},  32'(bus.rsp_valid_o), 32'd0);
    check({tag, "_rspid"}, 32'(bus.rsp_id_o),    32'd0);
    check({tag, "_match"}, 32'(bus.rsp_match_o), 32'd0);
    check({tag, "_err"},   32'(bus.rsp_err_o),   32'd0);
    check({tag, "_idle"},  32'(bus.idle_o),      32'd1);
  endtask

  // Bounded wait for a grant pulse; start must accompany it.
  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.gnt_o != 4'b0000) begin
        g = bus.gnt_o;
        check("start_with_gnt", 32'(bus.eng_start_o), 32'd1);
        break;
      end
    end
    check("grant_seen", 32'(g != 4'b0000), 32'd1);
  endtask

  // Called on the grant cycle: engine answers lat cycles into WAIT, response checked next cycle.
  task automatic reply(input int lat, input logic m, input logic [1:0] id,
                       input logic [1:0] exp_id, input logic exp_m, input logic exp_e);
    tick();
    check("gnt_one_cycle",   32'(bus.gnt_o),       32'd0);
    check("start_one_cycle", 32'(bus.eng_start_o), 32'd0);
    repeat (lat - 1) tick();
    bus.eng_valid_i = 1'b1;
    bus.eng_match_i = m;
    bus.eng_id_i    = id;
    tick();
    bus.eng_valid_i = 1'b0;
    bus.eng_match_i = 1'b0;
    bus.eng_id_i    = 2'd0;
    check("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("rsp_id",    32'(bus.rsp_id_o),    32'(exp_id));
    check("rsp_match", 32'(bus.rsp_match_o), 32'(exp_m));
    check("rsp_err",   32'(bus.rsp_err_o),   32'(exp_e));
    tick();
    check("rsp_pulse_end", 32'(bus.rsp_valid_o), 32'd0);
    check("idle_after",    32'(bus.idle_o),      32'd1);
  endtask

  initial begin
    logic [3:0] g;
    logic       saw_start;
    int         exp1 [4];
    int         exp2 [3];
    exp1 = '{0, 1, 2, 3};
    exp2 = '{0, 1, 3};
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.req_i       = 4'b0000;
    bus.eng_busy_i  = 1'b0;
    bus.eng_valid_i = 1'b0;
    bus.eng_match_i = 1'b0;
    bus.eng_id_i    = 2'd0;

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Fairness: all four request from rr_ptr=0, each drops only its own bit.
    bus.req_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check("fair1_gnt", 32'(g), 32'(4'b0001 << exp1[k]));
      check("fair1_sel", 32'(bus.sel_o), 32'(exp1[k]));
      bus.req_i = bus.req_i & ~g;
      reply(2, k[0], 2'(exp1[k]), 2'(exp1[k]), k[0], 1'b0);
    end
    bus.req_i = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g);
      check("fair2_gnt", 32'(g), 32'(4'b0001 << exp2[k]));
      bus.req_i = bus.req_i & ~g;
      reply(2, 1'b1, 2'(exp2[k]), 2'(exp2[k]), 1'b1, 1'b0);
    end

    // Single request: grant exactly one cycle after the request is seen.
    bus.req_i = 4'b0001;
    tick();
    check("single_gnt",   32'(bus.gnt_o),       32'h1);
    check("single_start", 32'(bus.eng_start_o), 32'd1);
    check("single_sel",   32'(bus.sel_o),       32'd0);
    bus.req_i = 4'b0000;
    reply(4, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);

    // Busy stall: no start while busy, start one cycle after busy falls.
    bus.eng_busy_i = 1'b1;
    bus.req_i      = 4'b0100;
    saw_start      = 1'b0;
    repeat (10) begin
      tick();
      saw_start = saw_start | bus.eng_start_o;
    end
    check("busy_no_start", 32'(saw_start),   32'd0);
    check("busy_idle",     32'(bus.idle_o),  32'd1);
    bus.eng_busy_i = 1'b0;
    tick();
    check("busy_gnt",   32'(bus.gnt_o),       32'h4);
    check("busy_start", 32'(bus.eng_start_o), 32'd1);
    bus.req_i = 4'b0000;
    reply(2, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0);

    // Id mismatch: engine reports client 2 for client 1's lookup.
    bus.req_i = 4'b0010;
    wait_grant(g);
    check("mis_gnt", 32'(g), 32'h2);
    bus.req_i = 4'b0000;
    reply(3, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1);

    // Engine strobe while idle has no effect.
    bus.eng_valid_i = 1'b1;
    bus.eng_match_i = 1'b1;
    tick();
    bus.eng_valid_i = 1'b0;
    bus.eng_match_i = 1'b0;
    check("idle_valid_ignored", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    check("idle_valid_no_rsp",  32'(bus.rsp_valid_o), 32'd0);
    check("idle_valid_idle",    32'(bus.idle_o),      32'd1);

`ifdef SQ_SCHED_TIMEOUT_EN
    // Watchdog: response with err exactly 8 cycles after entering WAIT.
    bus.req_i = 4'b0001;
    wait_grant(g);
    check("to_gnt", 32'(g), 32'h1);
    bus.req_i = 4'b0000;
    repeat (8) tick();
    check("to_not_early", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    check("to_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("to_rsp_err",   32'(bus.rsp_err_o),   32'd1);
    check("to_rsp_match", 32'(bus.rsp_match_o), 32'd0);
    check("to_rsp_id",    32'(bus.rsp_id_o),    32'd0);
    tick();
    bus.eng_valid_i = 1'b1;
    bus.eng_match_i = 1'b1;
    tick();
    bus.eng_valid_i = 1'b0;
    bus.eng_match_i = 1'b0;
    check("to_late_ignored", 32'(bus.rsp_valid_o), 32'd0);
    check("to_late_idle",    32'(bus.idle_o),      32'd1);
`endif

    // Reset in WAIT: everything clears, later strobe is ignored.
    bus.req_i = 4'b1000;
    wait_grant(g);
    check("rst_gnt", 32'(g), 32'h8);
    bus.req_i = 4'b0000;
    tick();
    tick();
    check("rst_pre_busy", 32'(bus.idle_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n           = 1'b1;
    bus.eng_valid_i = 1'b1;
    bus.eng_match_i = 1'b1;
    bus.eng_id_i    = 2'd3;
    tick();
    bus.eng_valid_i = 1'b0;
    bus.eng_match_i = 1'b0;
    bus.eng_id_i    = 2'd0;
    check_reset_outputs("postrst");
    tick();
    check("postrst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
